robot_map_sensor: RTL and testbench

- Parametrised grid-map and proximity-sensor model for the pipe-cleaner robot; next generation of the fixed 10x20 nibble-map block.
- Holds a ROWS x COLS map of 2-bit cells and the robot position, applies move/clean actions from the controller FSM, and returns registered head/left/right obstacle bits for the current orientation.
- Adds wall collision (bump), in-bounds clamping, dirt cells with a clean action, a remaining-dirt counter with a done flag, and a runtime map load port in place of file initialisation.

---
 rtl/robot_map_sensor.sv | 168 ++++++++++++++++
 tb/tb_robot_map_sensor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/robot_map_sensor.sv
// Grid map of 2-bit cells plus robot position; applies move/clean/load actions and
// registers head/left/right obstacle and dirt sensors for the post-action state.
module robot_map_sensor #(
  parameter int ROWS      = 10,
  parameter int COLS      = 20,
  parameter int START_ROW = 9,
  parameter int START_COL = 17,
  parameter int RW        = $clog2(ROWS),
  parameter int CW        = $clog2(COLS),
  parameter int DW        = $clog2(ROWS*COLS+1)
) (
  input  logic          clockc1,
  input  logic          reset,
  input  logic          load_en,
  input  logic [RW-1:0] load_row,
  input  logic [CW-1:0] load_col,
  input  logic [1:0]    load_data,
  input  logic [2:0]    acao,
  input  logic [2:0]    orientacao,
  output logic          head,
  output logic          left,
  output logic          right,
  output logic          bump,
  output logic          dirt_here,
  output logic [RW-1:0] robo_row,
  output logic [CW-1:0] robo_col,
  output logic [DW-1:0] dirt_left,
  output logic          done
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS-1);
  localparam logic [RW:0]   ROWS_EXT = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_EXT = (CW+1)'(COLS);
  localparam logic [1:0]    DIRT     = 2'b10;

  logic [1:0]    map_reg [ROWS][COLS];
  logic [RW-1:0] row_reg, row_next, tgt_row;
  logic [CW-1:0] col_reg, col_next, tgt_col;
  logic [DW-1:0] dirt_reg, dirt_next;
  logic          head_reg, left_reg, right_reg, bump_reg, dirt_here_reg;
  logic          head_next, left_next, right_next, bump_next, dirt_here_next;
  logic          is_move, is_clean, tgt_oob, blocked, load_ok;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [1:0]    wr_data, old_cell, here_cell;

  // Neighbours of the post-action position, index 0 N, 1 W, 2 E, 3 S
  logic [RW-1:0] nb_row [4];
  logic [CW-1:0] nb_col [4];
  logic [3:0]    nb_oob;
  logic [1:0]    nb_cell [4];
  logic [3:0]    nb_obs;

  always_comb begin
    is_move  = !load_en && (acao inside {[3'd1:3'd4]});
    is_clean = !load_en && (acao == 3'd5);
    tgt_row  = row_reg;
    tgt_col  = col_reg;
    tgt_oob  = 1'b0;
    case (acao)
      3'd1: begin tgt_oob = (row_reg == '0);      if (!tgt_oob) tgt_row = row_reg - 1'b1; end
      3'd2: begin tgt_oob = (col_reg == '0);      if (!tgt_oob) tgt_col = col_reg - 1'b1; end
      3'd3: begin tgt_oob = (col_reg == LAST_COL); if (!tgt_oob) tgt_col = col_reg + 1'b1; end
      3'd4: begin tgt_oob = (row_reg == LAST_ROW); if (!tgt_oob) tgt_row = row_reg + 1'b1; end
      default: ;
    endcase
    blocked   = tgt_oob || (map_reg[tgt_row][tgt_col] == 2'b01) || (map_reg[tgt_row][tgt_col] == 2'b11);
    row_next  = (is_move && !blocked) ? tgt_row : row_reg;
    col_next  = (is_move && !blocked) ? tgt_col : col_reg;
    bump_next = is_move && blocked;

    // A dropped load or a no-op clean aims the write port at the robot cell with wr_en low
    load_ok = ({1'b0, load_row} < ROWS_EXT) && ({1'b0, load_col} < COLS_EXT);
    wr_en   = load_en ? load_ok : (is_clean && map_reg[row_reg][col_reg] == DIRT);
    wr_row  = (load_en && load_ok) ? load_row : row_reg;
    wr_col  = (load_en && load_ok) ? load_col : col_reg;
    wr_data = load_en ? load_data : 2'b00;

    old_cell  = map_reg[wr_row][wr_col];
    dirt_next = dirt_reg;
    if (wr_en && old_cell == DIRT && wr_data != DIRT) begin
      if (dirt_reg != '0) dirt_next = dirt_reg - 1'b1;
    end else if (wr_en && old_cell != DIRT && wr_data == DIRT) begin
      dirt_next = dirt_reg + 1'b1;
    end

    here_cell = (wr_en && wr_row == row_next && wr_col == col_next) ? wr_data
                                                                    : map_reg[row_next][col_next];
    dirt_here_next = (here_cell == DIRT);

    for (int d = 0; d < 4; d++) begin
      nb_row[d] = row_next;
      nb_col[d] = col_next;
    end
    nb_oob[0] = (row_next == '0);
    nb_oob[1] = (col_next == '0);
    nb_oob[2] = (col_next == LAST_COL);
    nb_oob[3] = (row_next == LAST_ROW);
    if (!nb_oob[0]) nb_row[0] = row_next - 1'b1;
    if (!nb_oob[1]) nb_col[1] = col_next - 1'b1;
    if (!nb_oob[2]) nb_col[2] = col_next + 1'b1;
    if (!nb_oob[3]) nb_row[3] = row_next + 1'b1;
  end

  // Sensors see this cycle's write, so forward it over the stored cell
  for (genvar gi = 0; gi < 4; gi++) begin : g_nb
    assign nb_cell[gi] = (wr_en && wr_row == nb_row[gi] && wr_col == nb_col[gi]) ? wr_data
                                                                                 : map_reg[nb_row[gi]][nb_col[gi]];
    assign nb_obs[gi]  = nb_oob[gi] || (nb_cell[gi] != 2'b00 && nb_cell[gi] != DIRT);
  end

  always_comb begin
    {head_next, left_next, right_next} = 3'b000;
    case (orientacao)
      3'd1: {head_next, left_next, right_next} = {nb_obs[0], nb_obs[1], nb_obs[2]};
      3'd2: {head_next, left_next, right_next} = {nb_obs[1], nb_obs[3], nb_obs[0]};
      3'd3: {head_next, left_next, right_next} = {nb_obs[2], nb_obs[0], nb_obs[3]};
      3'd4: {head_next, left_next, right_next} = {nb_obs[3], nb_obs[2], nb_obs[1]};
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      always_ff @(posedge clockc1) begin
        if (reset)
          map_reg[gi][gj] <= 2'b00;
        else if (wr_en && wr_row == RW'(gi) && wr_col == CW'(gj))
          map_reg[gi][gj] <= wr_data;
      end
    end
  end

  always_ff @(posedge clockc1) begin
    if (reset) begin
      row_reg       <= RW'(START_ROW);
      col_reg       <= CW'(START_COL);
      dirt_reg      <= '0;
      head_reg      <= 1'b0;
      left_reg      <= 1'b0;
      right_reg     <= 1'b0;
      bump_reg      <= 1'b0;
      dirt_here_reg <= 1'b0;
    end else begin
      row_reg       <= row_next;
      col_reg       <= col_next;
      dirt_reg      <= dirt_next;
      head_reg      <= head_next;
      left_reg      <= left_next;
      right_reg     <= right_next;
      bump_reg      <= bump_next;
      dirt_here_reg <= dirt_here_next;
    end
  end

  assign head      = head_reg;
  assign left      = left_reg;
  assign right     = right_reg;
  assign bump      = bump_reg;
  assign dirt_here = dirt_here_reg;
  assign robo_row  = row_reg;
  assign robo_col  = col_reg;
  assign dirt_left = dirt_reg;
  assign done      = (dirt_reg == '0);

endmodule

// File: tb/tb_robot_map_sensor.sv
// Directed and random checks of robot_map_sensor against a grid model that uses
// direction vectors and rotation to derive the sensors.
module tb_robot_map_sensor;
  localparam int ROWS = 10;
  localparam int COLS = 20;
  localparam int SR   = 9;
  localparam int SC   = 17;
  localparam int RW   = 4;
  localparam int CW   = 5;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset, load_en;
  logic [RW-1:0] load_row;
  logic [CW-1:0] load_col;
  logic [1:0]    load_data;
  logic [2:0]    acao, orientacao;
  logic          head, left, right, bump, dirt_here, done;
  logic [RW-1:0] robo_row;
  logic [CW-1:0] robo_col;
  logic [DW-1:0] dirt_left;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Reference model state
  int mm [ROWS][COLS];
  int pr, pc;
  bit e_head, e_left, e_right, e_bump, e_dh;

  robot_map_sensor dut (
    .clockc1(clk), .reset(reset), .load_en(load_en), .load_row(load_row),
    .load_col(load_col), .load_data(load_data), .acao(acao), .orientacao(orientacao),
    .head(head), .left(left), .right(right), .bump(bump), .dirt_here(dirt_here),
    .robo_row(robo_row), .robo_col(robo_col), .dirt_left(dirt_left), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit obst(int r, int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b1;
    return (mm[r][c] == 1 || mm[r][c] == 3);
  endfunction

  task automatic dir_vec(input int code, output int dr, output int dc);
    dr = 0; dc = 0;
    case (code)
      1: dr = -1;
      2: dc = -1;
      3: dc = 1;
      4: dr = 1;
      default: ;
    endcase
  endtask

  function automatic int dirt_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mm[r][c] == 2) n++;
    return n;
  endfunction

  task automatic model(input bit rs, input bit le, input int lr, input int lc, input int ld,
                       input int ac, input int ori);
    int dr, dc;
    if (rs) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mm[r][c] = 0;
      pr = SR; pc = SC;
      {e_head, e_left, e_right, e_bump, e_dh} = 5'b0;
      return;
    end
    e_bump = 1'b0;
    if (le) begin
      if (lr < ROWS && lc < COLS) mm[lr][lc] = ld;
    end else if (ac >= 1 && ac <= 4) begin
      dir_vec(ac, dr, dc);
      if (obst(pr + dr, pc + dc)) e_bump = 1'b1;
      else begin pr = pr + dr; pc = pc + dc; end
    end else if (ac == 5 && mm[pr][pc] == 2) begin
      mm[pr][pc] = 0;
    end
    // left is the facing vector turned 90 degrees counter-clockwise, right clockwise
    if (ori >= 1 && ori <= 4) begin
      dir_vec(ori, dr, dc);
      e_head  = obst(pr + dr, pc + dc);
      e_left  = obst(pr - dc, pc + dr);
      e_right = obst(pr + dc, pc - dr);
    end else begin
      {e_head, e_left, e_right} = 3'b0;
    end
    e_dh = (mm[pr][pc] == 2);
  endtask

  task automatic step(input bit rs, input bit le, input int lr, input int lc, input int ld,
                      input int ac, input int ori);
    int nd;
    reset = rs; load_en = le; load_row = RW'(lr); load_col = CW'(lc);
    load_data = 2'(ld); acao = 3'(ac); orientacao = 3'(ori);
    @(posedge clk);
    model(rs, le, lr, lc, ld, ac, ori);
    #1;
    nd = dirt_count();
    chk("robo_row", robo_row, pr);
    chk("robo_col", robo_col, pc);
    chk("dirt_left", dirt_left, nd);
    chk("done", done, (nd == 0));
    chk("head", head, e_head);
    chk("left", left, e_left);
    chk("right", right, e_right);
    chk("bump", bump, e_bump);
    chk("dirt_here", dirt_here, e_dh);
    txn++;
    $display("txn %0d rst=%0d ld=%0d (%0d,%0d)=%0d acao=%0d ori=%0d -> pos=(%0d,%0d) hlr=%0d%0d%0d bump=%0d dh=%0d dirt=%0d",
             txn, rs, le, lr, lc, ld, ac, ori, robo_row, robo_col, head, left, right, bump,
             dirt_here, dirt_left);
  endtask

  task automatic idle(input int ori);
    step(0, 0, 0, 0, 0, 0, ori);
  endtask

  task automatic load(input int r, input int c, input int d, input int ori);
    step(0, 1, r, c, d, 0, ori);
  endtask

  task automatic act(input int ac, input int ori);
    step(0, 0, 0, 0, 0, ac, ori);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 1);
    chk("rst_row_const", robo_row, 9);
    chk("rst_col_const", robo_col, 17);
    chk("rst_done_const", done, 1);
    idle(1);
    chk("idle_hlr_const", {head, left, right}, 3'b000);

    // Wall ahead blocks north move
    load(8, 17, 1, 1);
    act(1, 1);
    chk("bump_north_const", bump, 1);
    chk("head_wall_const", head, 1);
    idle(1);
    chk("bump_clear_const", bump, 0);

    // South edge, then east to the east edge
    act(4, 1);
    chk("bump_south_const", bump, 1);
    act(3, 1);
    act(3, 1);
    chk("col19_const", robo_col, 19);
    act(3, 1);
    chk("bump_east_const", bump, 1);

    // Dirt loading, moving onto dirt, cleaning
    load(9, 16, 2, 1);
    load(5, 5, 2, 1);
    chk("dirt2_const", dirt_left, 2);
    act(2, 1);
    act(2, 1);
    act(2, 1);
    chk("dh_const", dirt_here, 1);
    chk("dirt_still2_const", dirt_left, 2);
    act(5, 1);
    chk("dirt1_const", dirt_left, 1);
    act(5, 1);
    chk("dirt_stay1_const", dirt_left, 1);
    load(5, 5, 0, 1);
    chk("done_const", done, 1);
    load(12, 5, 2, 1);
    chk("oob_load_const", dirt_left, 0);
    load(3, 25, 2, 1);
    // Wall loaded onto the robot's own cell
    load(9, 16, 3, 1);
    chk("own_wall_col_const", robo_col, 16);

    // Orientation sweep at (4,4) with walls north and east
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) act(1, 1);
    for (int i = 0; i < 13; i++) act(2, 1);
    load(3, 4, 1, 1);
    load(4, 5, 3, 1);
    idle(1);
    chk("sweep_n_const", {head, left, right}, 3'b101);
    idle(2);
    chk("sweep_w_const", {head, left, right}, 3'b001);
    idle(3);
    chk("sweep_e_const", {head, left, right}, 3'b110);
    idle(4);
    chk("sweep_s_const", {head, left, right}, 3'b010);
    idle(0);
    chk("sweep_inv_const", {head, left, right}, 3'b000);
    step(1, 1, 4, 4, 2, 3, 3);
    chk("mid_rst_hlr_const", {head, left, right, bump, dirt_here}, 5'b0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit rs, le;
      rs = ($urandom_range(0, 99) == 0);
      le = ($urandom_range(0, 99) < 30);
      step(rs, le, $urandom_range(0, 11), $urandom_range(0, 21), $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
